// File: rtl/iomem_router_if.sv
// iomem_router_if: picosoc iomem bus plus the shared slot-side request bus.
interface iomem_router_if #(parameter int NSLV = 4);
   logic              iomem_valid;
   logic              iomem_ready;
   logic [3:0]        iomem_wstrb;
   logic [31:0]       iomem_addr;
   logic [31:0]       iomem_wdata;
   logic [31:0]       iomem_rdata;
   logic [NSLV-1:0]   s_valid;
   logic [NSLV-1:0]   s_ready;
   logic [3:0]        s_wstrb;
   logic [31:0]       s_addr;
   logic [31:0]       s_wdata;
   logic [NSLV*32-1:0] s_rdata;
   modport slave (
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, s_ready, s_rdata,
      output iomem_ready, iomem_rdata, s_valid, s_wstrb, s_addr, s_wdata
   );
   modport master (
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, s_ready, s_rdata,
      input  iomem_ready, iomem_rdata, s_valid, s_wstrb, s_addr, s_wdata
   );
endinterface

// File: rtl/iomem_router.sv
// iomem_router: decodes addr[31:24] onto NSLV slots, always answers the CPU
// (slot data, or ERR_RDATA on timeout / decode miss).
module iomem_router #(
   parameter int          NSLV      = 4,
   parameter logic [7:0]  BASE      = 8'h03,
   parameter int          TIMEOUT   = 255,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic           clk,
   input  logic           resetn,
   iomem_router_if.slave  bus,
   output logic [7:0]     err_count
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int SW = NSLV > 1 ? $clog2(NSLV) : 1;
   localparam logic [7:0] LAST = BASE + 8'(NSLV - 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NSLV-1:0] s_valid_q, s_valid_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [7:0]      err_q, err_d;
   logic [7:0]      top, off, err_inc;
   logic            hit;

   assign top     = bus.iomem_addr[31:24];
   assign off     = top - BASE;
   assign hit     = top >= BASE && top <= LAST;
   assign err_inc = err_q == 8'hFF ? err_q : err_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      s_valid_d = s_valid_q;
      wstrb_d   = wstrb_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      if (state_q == IDLE && bus.iomem_valid) begin
         wstrb_d = bus.iomem_wstrb;
         addr_d  = bus.iomem_addr;
         wdata_d = bus.iomem_wdata;
         if (hit) begin
            sel_d     = off[SW-1:0];
            s_valid_d = NSLV'(1) << off[SW-1:0];
            cnt_d     = '0;
            state_d   = BUSY;
         end else begin
            rdata_d = ERR_RDATA;
            err_d   = err_inc;
            state_d = DONE;
         end
      end else if (state_q == BUSY) begin
         // a ready arriving on the final timeout cycle still wins
         if (bus.s_ready[sel_q]) begin
            rdata_d   = bus.s_rdata[32*sel_q +: 32];
            s_valid_d = '0;
            state_d   = DONE;
         end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rdata_d   = ERR_RDATA;
            s_valid_d = '0;
            err_d     = err_inc;
            state_d   = DONE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         cnt_q     <= '0;
         s_valid_q <= '0;
         wstrb_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         s_valid_q <= s_valid_d;
         wstrb_q   <= wstrb_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign bus.iomem_ready = state_q == DONE;
   assign bus.iomem_rdata = rdata_q;
   assign bus.s_valid     = s_valid_q;
   assign bus.s_wstrb     = wstrb_q;
   assign bus.s_addr      = addr_q;
   assign bus.s_wdata     = wdata_q;
   assign err_count       = err_q;
endmodule

// File: tb/tb_iomem_router.sv
// tb_iomem_router: directed + random requests against a latency/data model
// derived from the slot map, wait counts and timeout rule.
module tb_iomem_router;
   localparam int NS = 4;
   localparam int TO = 8;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic [7:0] err_count;
   int checks = 0;
   int errors = 0;
   int model_err = 0;
   logic [31:0] slot_data [NS];

   iomem_router_if #(.NSLV(NS)) bus ();

   iomem_router #(.NSLV(NS), .BASE(8'h03), .TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
      .clk(clk), .resetn(resetn), .bus(bus.slave), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // wn: cycles the selected slot waits before s_ready (-1 = never)
   task automatic run_req(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                          input int wn, input bit noise);
      logic [7:0] top;
      logic [31:0] erd;
      logic [3:0] esv;
      bit hit, done;
      int slot, lat;
      top = a[31:24];
      hit = top >= 8'h03 && top <= 8'h06;
      slot = hit ? int'(top) - 3 : 0;
      if (!hit) begin
         lat = 1; erd = ERR; model_err = model_err < 255 ? model_err + 1 : 255;
      end else if (wn >= 0 && wn < TO) begin
         lat = 2 + wn; erd = slot_data[slot];
      end else begin
         lat = TO + 1; erd = ERR; model_err = model_err < 255 ? model_err + 1 : 255;
      end
      esv = hit ? 4'b0001 << slot : 4'b0000;
      for (int k = 0; k < NS; k++) bus.s_rdata[32*k +: 32] = slot_data[k];
      bus.iomem_valid = 1'b1;
      bus.iomem_addr = a;
      bus.iomem_wstrb = ws;
      bus.iomem_wdata = wd;
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         chk("s_valid", bus.s_valid, (c <= lat - 2) ? esv : 4'b0000);
         if (hit && c <= lat - 2) begin
            chk("s_addr", bus.s_addr, a);
            chk("s_wstrb", bus.s_wstrb, ws);
            chk("s_wdata", bus.s_wdata, wd);
         end
         for (int k = 0; k < NS; k++)
            bus.s_ready[k] = (hit && k == slot) ? (c == wn) : (noise ? 1'($urandom % 2) : 1'b0);
         if (bus.iomem_ready) begin
            done = 1;
            chk("latency", c + 1, lat);
            chk("rdata", bus.iomem_rdata, erd);
            bus.iomem_valid = 1'b0;
         end
      end
      chk("ready_seen", done, 1'b1);
      bus.iomem_valid = 1'b0;
      bus.s_ready = '0;
      @(negedge clk);
      chk("ready_pulse", bus.iomem_ready, 1'b0);
      chk("rdata_hold", bus.iomem_rdata, erd);
      chk("err_count", err_count, model_err[7:0]);
   endtask

   initial begin
      bus.iomem_valid = 1'b0;
      bus.iomem_addr = '0;
      bus.iomem_wstrb = '0;
      bus.iomem_wdata = '0;
      bus.s_ready = '0;
      bus.s_rdata = '0;
      for (int k = 0; k < NS; k++) slot_data[k] = $urandom;
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.iomem_ready, 1'b0);
      chk("rst_rdata", bus.iomem_rdata, 32'h0);
      chk("rst_s_valid", bus.s_valid, 4'b0);
      chk("rst_s_addr", bus.s_addr, 32'h0);
      chk("rst_err", err_count, 8'h0);
      resetn = 1'b1;
      @(negedge clk);
      slot_data[1] = 32'h1234_5678;
      run_req(32'h0400_0000, 4'b0000, 32'h0, 0, 0);
      run_req(32'h0300_0000, 4'b0101, 32'hA5A5_5A5A, 3, 0);
      run_req(32'h0500_0000, 4'b0000, 32'h0, -1, 0);
      slot_data[2] = 32'hC0DE_0002;
      run_req(32'h0500_0010, 4'b0000, 32'h0, TO - 1, 0);
      run_req(32'h0800_0000, 4'b0000, 32'h0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < NS; k++) slot_data[k] = $urandom;
         run_req({8'($urandom_range(0, 9)), 24'($urandom)}, 4'($urandom), $urandom,
                 int'($urandom_range(0, 11)) - 1, 1);
      end
      for (int i = 0; i < 300; i++)
         run_req({8'($urandom_range(7, 255)), 24'($urandom)}, 4'b0000, 32'h0, 0, 1);
      chk("err_sat", err_count, 8'd255);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr = 32'h0600_0000;
      bus.iomem_wstrb = 4'b0000;
      repeat (3) @(negedge clk);
      chk("busy_s_valid", bus.s_valid, 4'b1000);
      #2 resetn = 1'b0;
      #1;
      chk("arst_s_valid", bus.s_valid, 4'b0);
      chk("arst_ready", bus.iomem_ready, 1'b0);
      chk("arst_err", err_count, 8'h0);
      bus.iomem_valid = 1'b0;
      model_err = 0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      slot_data[3] = 32'h0BAD_F00D;
      run_req(32'h0600_0004, 4'b1111, 32'h5555_AAAA, 1, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
